// File: rtl/wtile_col_prefetch_db.sv
// Double-buffered weight-column prefetcher: fills one column of M rows, LANES words per SRAM beat, while the other buffer is consumed.
// Unstalled latency is M/LANES+2 cycles from start. CPU writes stall issue, and a write to the column being filled restarts the fill.
module wtile_col_prefetch_db #(
    parameter int M      = 8,
    parameter int KMAX   = 1024,
    parameter int DATA_W = 32,
    parameter int BYTE_W = DATA_W / 8,
    parameter int LANES  = 2,
    parameter int ROW_W  = (M <= 1) ? 1 : $clog2(M),
    parameter int K_W    = (KMAX <= 1) ? 1 : $clog2(KMAX)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_k,
    input  logic [K_W-1:0]            k_idx,
    output logic                      start_ready,
    output logic                      col_valid,
    input  logic                      col_accept,
    output logic [K_W-1:0]            col_k,
    output logic [M*DATA_W-1:0]       col_data,
    input  logic                      cpu_w_we,
    input  logic [ROW_W-1:0]          cpu_w_row,
    input  logic [K_W-1:0]            cpu_w_k,
    input  logic [DATA_W-1:0]         cpu_w_wdata,
    input  logic [BYTE_W-1:0]         cpu_w_wmask,
    output logic                      sram_en,
    output logic                      sram_re,
    output logic                      sram_we,
    output logic [ROW_W-1:0]          sram_row,
    output logic [K_W-1:0]            sram_k,
    output logic [DATA_W-1:0]         sram_wdata,
    output logic [BYTE_W-1:0]         sram_wmask,
    input  logic [LANES*DATA_W-1:0]   sram_rdata,
    input  logic                      sram_rvalid,
    output logic                      busy,
    output logic [15:0]               refetch_cnt
);

    localparam int NB    = M / LANES;
    localparam int CNT_W = $clog2(NB + 1);
    localparam logic [CNT_W-1:0] NB_C   = CNT_W'(NB);
    localparam logic [CNT_W-1:0] NB_END = CNT_W'(NB - 1);

    typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL} buf_st_t;
    typedef enum logic {S_IDLE, S_FILL} fsm_t;

    fsm_t              state;
    buf_st_t           buf_st  [2];
    logic [K_W-1:0]    buf_tag [2];
    logic [DATA_W-1:0] buf_dat [2][M];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  beat_cnt;
    logic              restart;
    logic              rd_pend;

    logic              start_acc;
    logic              fill_act;
    logic              issue_go;
    logic              hazard;
    logic              beat_ok;
    logic              last_beat;

    assign start_ready = (state == S_IDLE) && (buf_st[wr_ptr] == B_FREE);
    assign start_acc   = start_k && start_ready;
    assign fill_act    = (state == S_FILL);
    assign busy        = fill_act;
    assign issue_go    = fill_act && (issue_cnt < NB_C) && !cpu_w_we && !restart;
    assign hazard      = fill_act && cpu_w_we && (cpu_w_k == buf_tag[wr_ptr]);
    // rd_pend gates rvalid so beats from before a reset or a restart never land
    assign beat_ok     = fill_act && sram_rvalid && rd_pend && !restart;
    assign last_beat   = beat_ok && (beat_cnt == NB_END) && !hazard;

    assign col_valid = (buf_st[rd_ptr] == B_FULL);
    assign col_k     = buf_tag[rd_ptr];

    for (genvar r = 0; r < M; r++) begin : g_col
        assign col_data[r*DATA_W +: DATA_W] = buf_dat[rd_ptr][r];
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_re    = 1'b0;
        sram_we    = 1'b0;
        sram_row   = '0;
        sram_k     = '0;
        sram_wdata = '0;
        sram_wmask = '0;
        if (cpu_w_we) begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_row   = cpu_w_row;
            sram_k     = cpu_w_k;
            sram_wdata = cpu_w_wdata;
            sram_wmask = cpu_w_wmask;
        end else if (issue_go) begin
            sram_en  = 1'b1;
            sram_re  = 1'b1;
            sram_row = ROW_W'(int'(issue_cnt) * LANES);
            sram_k   = buf_tag[wr_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            issue_cnt   <= '0;
            beat_cnt    <= '0;
            restart     <= 1'b0;
            rd_pend     <= 1'b0;
            refetch_cnt <= '0;
            for (int b = 0; b < 2; b++) begin
                buf_st[b]  <= B_FREE;
                buf_tag[b] <= '0;
                for (int r = 0; r < M; r++) begin
                    buf_dat[b][r] <= '0;
                end
            end
        end else begin
            rd_pend <= issue_go;

            if (col_valid && col_accept) begin
                buf_st[rd_ptr] <= B_FREE;
                rd_ptr         <= ~rd_ptr;
            end

            if (hazard && (refetch_cnt != 16'hFFFF)) begin
                refetch_cnt <= refetch_cnt + 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (start_acc) begin
                        buf_tag[wr_ptr] <= k_idx;
                        buf_st[wr_ptr]  <= B_FILLING;
                        issue_cnt       <= '0;
                        beat_cnt        <= '0;
                        restart         <= 1'b0;
                        state           <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (issue_go) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    end
                    if (beat_ok) begin
                        for (int l = 0; l < LANES; l++) begin
                            buf_dat[wr_ptr][ROW_W'(int'(beat_cnt) * LANES + l)] <= sram_rdata[l*DATA_W +: DATA_W];
                        end
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                    // a fresh hazard wins over clearing a previous restart
                    if (hazard) begin
                        restart <= 1'b1;
                    end else if (restart && !rd_pend) begin
                        restart   <= 1'b0;
                        issue_cnt <= '0;
                        beat_cnt  <= '0;
                    end else if (last_beat) begin
                        buf_st[wr_ptr] <= B_FULL;
                        wr_ptr         <= ~wr_ptr;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
